alu_share_arbiter: RTL

- Shares one registered 2-bit-opcode ALU (A, B, S in; out registered) among NREQ requesters.
- Round-robin arbitration over valid/ready request channels; issues one operation at a time to the ALU.
- Waits out the ALU latency, then returns the result tagged with the requester ID on a valid/ready response channel.
- Sits between client blocks and the single ALU instance, which shares its clock and reset.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu_share_arbiter_if.sv | 48 ++++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types for the ALU-sharing arbiter.
//   state_t  : arbiter FSM state (IDLE -> WAIT -> RESP -> IDLE).
//   alu_op_t : 2-bit ALU opcode; carried through the arbiter untouched.
//   OP_*     : opcode encodings understood by the ALU (the arbiter ignores them).
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 2'd0;
    localparam alu_op_t OP_SUB = 2'd1;
    localparam alu_op_t OP_AND = 2'd2;
    localparam alu_op_t OP_OR  = 2'd3;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles the request channels, the response channel and the ALU-side bus of
// the ALU-sharing arbiter.
//   req_valid/req_ready : per-requester handshake (NREQ bits each)
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op              : packed opcodes, requester i at [i*2 +: 2]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_data     : owning requester index and ALU result
//   alu_a/alu_b/alu_s   : operands/opcode driven to the shared ALU
//   alu_out             : registered ALU result
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters, response sink and ALU)
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    alu_op_t               alu_s;
    logic [WIDTH-1:0]      alu_out;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
        output req_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_s
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
        input  req_ready, rsp_valid, rsp_id, rsp_data, alu_a, alu_b, alu_s
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotate-priority pick: the first set bit of req found scanning
// upward from ptr, wrapping at NREQ.
//   req       in  NREQ  request vector
//   ptr       in  IDW   index with highest priority this cycle
//   grant     out NREQ  one-hot grant (all zero when nothing requests)
//   grant_idx out IDW   index of the granted bit (0 when none)
//   grant_any out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    always_comb begin
        int unsigned pos;
        logic [IDW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // NREQ need not be a power of two, so wrap with modulo instead of
            // relying on index overflow.
            pos = (int'(ptr) + k) % NREQ;
            idx = IDW'(pos);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one registered ALU among NREQ requesters. One operation is in flight
// at a time: a round-robin winner is accepted in IDLE, its operands are
// registered onto the ALU bus, the ALU latency is waited out in WAIT, and the
// result is presented with the winner's index in RESP until accepted.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A sender keeps valid and payload stable
// until that edge; req_ready never depends on anything other than req_valid,
// the FSM state, the rr pointer and reset. Dropping req_valid before the
// grant is legal.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high; reset wins over a handshake
//   bus       slave modport of alu_share_arbiter_if (requests, response, ALU)
//   dbg_state out  current FSM state
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_share_arbiter_if.slave    bus,
    output state_t                dbg_state
);

    localparam int IDW   = $clog2(NREQ);
    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    state_t           state_q,     state_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    alu_op_t          alu_s_q,     alu_s_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic [NREQ-1:0]  req_ready_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_c = '0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready_c = grant;
                    alu_a_d     = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    alu_b_d     = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    alu_s_d     = bus.req_op[int'(grant_idx)*2 +: 2];
                    rsp_id_d    = grant_idx;
                    ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    // Counting ALU_LAT down to 0 gives ALU_LAT+1 WAIT cycles:
                    // one for the operand register, ALU_LAT for the ALU.
                    cnt_d       = CNT_W'(ALU_LAT);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = bus.alu_out;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Masking with reset keeps a requester from seeing a completed handshake
    // in a cycle whose edge will be swallowed by reset.
    assign bus.req_ready = reset ? '0 : req_ready_c;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign dbg_state     = state_q;

endmodule
